// File: rtl/mux_scan_pkg.sv
// Shared types and default sizes for the mux-tree scan controller.
package mux_scan_pkg;

    localparam int SCAN_SEL_W  = 9;
    localparam int SCAN_WORD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_HOLD
    } scan_state_e;

endpackage

// File: rtl/mux_scan_pack.sv
// LSB-first bit packer: each push writes one sample into the next bit slot of the word.
module mux_scan_pack
    import mux_scan_pkg::*;
#(
    parameter int WORD_W = SCAN_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              bit_in,
    output logic [WORD_W-1:0] data,
    output logic              full
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [IDX_W-1:0] bit_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data    <= '0;
            bit_idx <= '0;
        end else if (clear) begin
            data    <= '0;
            bit_idx <= '0;
        end else if (push) begin
            for (int i = 0; i < WORD_W; i++) begin
                if (bit_idx == IDX_W'(i)) begin
                    data[i] <= bit_in;
                end
            end
            bit_idx <= bit_idx + IDX_W'(1);
        end
    end

    // High when the current push lands in the top slot and so completes the word.
    assign full = push && (bit_idx == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sweeps the mux-tree select over a programmed range, samples Z after a settle
// delay and streams the samples out as packed words over valid/ready.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SEL_W  = SCAN_SEL_W,
    parameter int SETTLE = 2,
    parameter int WORD_W = SCAN_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SEL_W-1:0]  first_sel,
    input  logic [SEL_W-1:0]  last_sel,
    output logic [SEL_W-1:0]  sel,
    input  logic              z_in,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    // With no settle time the controller samples back-to-back, skipping SETTLE entirely.
    localparam scan_state_e WAIT_ST = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

    scan_state_e state;
    scan_state_e state_next;

    logic [SEL_W:0]   remaining;
    logic [SEL_W-1:0] span;
    logic [CNT_W-1:0] settle_cnt;
    logic             last_taken;
    logic             accept;
    logic             is_last;
    logic             settle_done;
    logic             pack_clear;
    logic             pack_push;
    logic             pack_full;

    // The done cycle itself refuses start so a new scan can only begin afterwards.
    assign accept      = (state == S_IDLE) && start && !done;
    assign is_last     = (remaining == (SEL_W + 1)'(1));
    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign span        = last_sel - first_sel;

    assign out_valid = (state == S_HOLD);
    assign out_last  = (state == S_HOLD) && last_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pack_clear = 1'b0;
        pack_push  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = WAIT_ST;
                    pack_clear = 1'b1;
                end
            end
            S_SETTLE: begin
                if (settle_done) begin
                    state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                pack_push = 1'b1;
                if (pack_full || is_last) begin
                    state_next = S_HOLD;
                end else begin
                    state_next = WAIT_ST;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (last_taken) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = WAIT_ST;
                        pack_clear = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Sample count is span+1, so a full-range scan needs the extra counter bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= '0;
            remaining  <= '0;
            settle_cnt <= '0;
            last_taken <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_SETTLE && !settle_done) begin
                settle_cnt <= settle_cnt + CNT_W'(1);
            end else begin
                settle_cnt <= '0;
            end
            if (accept) begin
                sel        <= first_sel;
                remaining  <= {1'b0, span} + (SEL_W + 1)'(1);
                last_taken <= 1'b0;
                busy       <= 1'b1;
            end
            if (state == S_SAMPLE) begin
                sel       <= sel + SEL_W'(1);
                remaining <= remaining - (SEL_W + 1)'(1);
                if (is_last) begin
                    last_taken <= 1'b1;
                end
            end
            if (state == S_HOLD && out_ready && last_taken) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

    mux_scan_pack #(
        .WORD_W (WORD_W)
    ) u_pack (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (pack_clear),
        .push   (pack_push),
        .bit_in (z_in),
        .data   (out_data),
        .full   (pack_full)
    );

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural mux-tree model driving z_in from sel.
module tb_mux_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [8:0]  first_sel;
    logic [8:0]  last_sel;
    logic [8:0]  sel;
    logic        z_in;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    logic [31:0] got_words[$];
    bit          got_last[$];
    logic [8:0]  sel_seq[$];
    int          done_cnt;
    int          done_cyc;
    int          last_hs_cyc;
    int          sel_changes;
    int          stall_seen;
    bit          stable;
    logic [8:0]  stall_sel;
    int          hs;

    mux_scan_ctrl #(
        .SEL_W  (9),
        .SETTLE (2),
        .WORD_W (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .first_sel (first_sel),
        .last_sel  (last_sel),
        .sel       (sel),
        .z_in      (z_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mux-tree stand-in: the pattern seen on Z depends on the scenario.
    always_comb begin
        case (mode)
            0:       z_in = sel[0];
            1:       z_in = 1'b1;
            2:       z_in = (sel == 9'd511);
            default: z_in = sel[1] ^ sel[5];
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int first, input int last);
        first_sel = 9'(first);
        last_sel  = 9'(last);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Runs one scan with optional stall on one word and an optional stray start pulse.
    task automatic runScan(input int first, input int last, input int stall_word,
                           input int stall_len, input int inject_at);
        logic [8:0]  prev_sel;
        logic [31:0] ref_data;
        int          stall_cnt;
        got_words.delete();
        got_last.delete();
        sel_seq.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        last_hs_cyc = -100;
        sel_changes = 0;
        stable      = 1'b1;
        stall_cnt   = 0;
        ref_data    = '0;
        stall_sel   = '0;
        prev_sel    = sel;
        out_ready   = 1'b1;
        applyStimulus(first, last);
        for (int cyc = 1; cyc < 4000 && done_cnt == 0; cyc++) begin
            if (sel !== prev_sel) begin
                sel_changes++;
                sel_seq.push_back(sel);
                prev_sel = sel;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            start = (cyc == inject_at);
            if (cyc == inject_at) begin
                first_sel = 9'd100;
                last_sel  = 9'd120;
            end
            if (out_valid) begin
                if (got_words.size() == stall_word && stall_cnt < stall_len) begin
                    if (stall_cnt == 0) begin
                        ref_data  = out_data;
                        stall_sel = sel;
                    end else if (out_data !== ref_data || sel !== stall_sel) begin
                        stable = 1'b0;
                    end
                    stall_cnt++;
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                    got_words.push_back(out_data);
                    got_last.push_back(out_last);
                    last_hs_cyc = cyc;
                end
            end else begin
                if (stall_cnt > 0 && stall_cnt < stall_len) begin
                    stable = 1'b0;
                end
                out_ready = 1'b1;
            end
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (done) begin
                done_cnt++;
            end
            tick();
        end
        stall_seen = stall_cnt;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        first_sel = '0;
        last_sel  = '0;
        out_ready = 1'b1;
        tick();
        tick();
        checkOutput("reset_sel", 32'(sel), 32'd0);
        checkOutput("reset_out_data", out_data, 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_last", 32'(out_last), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] full sweep 0..511");
        mode = 0;
        runScan(0, 511, -1, 0, -1);
        checkOutput("sweep_word_count", 32'(got_words.size()), 32'd16);
        for (int i = 0; i < got_words.size(); i++) begin
            checkOutput($sformatf("sweep_word%0d", i), got_words[i], 32'hAAAAAAAA);
            checkOutput($sformatf("sweep_last%0d", i), 32'(got_last[i]), 32'(i == 15));
        end
        checkOutput("sweep_samples", 32'(sel_changes), 32'd512);
        checkOutput("sweep_done_count", 32'(done_cnt), 32'd1);
        checkOutput("sweep_done_timing", 32'(done_cyc), 32'(last_hs_cyc + 1));

        $display("[TB] single sample at 10");
        mode = 1;
        applyStimulus(10, 10);
        checkOutput("single_c1_sel", 32'(sel), 32'd10);
        checkOutput("single_c1_busy", 32'(busy), 32'd1);
        checkOutput("single_c1_valid", 32'(out_valid), 32'd0);
        tick();
        tick();
        checkOutput("single_c3_sel", 32'(sel), 32'd10);
        checkOutput("single_c3_valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("single_c4_valid", 32'(out_valid), 32'd1);
        checkOutput("single_c4_data", out_data, 32'h00000001);
        checkOutput("single_c4_last", 32'(out_last), 32'd1);
        checkOutput("single_c4_sel", 32'(sel), 32'd11);
        checkOutput("single_c4_done", 32'(done), 32'd0);
        tick();
        checkOutput("single_c5_done", 32'(done), 32'd1);
        checkOutput("single_c5_busy", 32'(busy), 32'd0);
        checkOutput("single_c5_valid", 32'(out_valid), 32'd0);
        first_sel = 9'd10;
        last_sel  = 9'd10;
        start     = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("single_c6_done", 32'(done), 32'd0);
        checkOutput("single_c6_busy_start_in_done", 32'(busy), 32'd0);
        checkOutput("single_c6_sel", 32'(sel), 32'd11);

        $display("[TB] wrap-around 510..1");
        mode = 2;
        runScan(510, 1, -1, 0, -1);
        checkOutput("wrap_word_count", 32'(got_words.size()), 32'd1);
        if (got_words.size() > 0) begin
            checkOutput("wrap_word", got_words[0], 32'h00000002);
            checkOutput("wrap_last", 32'(got_last[0]), 32'd1);
        end
        checkOutput("wrap_sel_steps", 32'(sel_seq.size()), 32'd5);
        if (sel_seq.size() == 5) begin
            checkOutput("wrap_sel0", 32'(sel_seq[0]), 32'd510);
            checkOutput("wrap_sel1", 32'(sel_seq[1]), 32'd511);
            checkOutput("wrap_sel2", 32'(sel_seq[2]), 32'd0);
            checkOutput("wrap_sel3", 32'(sel_seq[3]), 32'd1);
            checkOutput("wrap_sel4", 32'(sel_seq[4]), 32'd2);
        end
        checkOutput("wrap_done_count", 32'(done_cnt), 32'd1);

        $display("[TB] backpressure on first word of 0..63");
        mode = 3;
        runScan(0, 63, 0, 20, -1);
        checkOutput("bp_stall_cycles", 32'(stall_seen), 32'd20);
        checkOutput("bp_stall_sel", 32'(stall_sel), 32'd32);
        checkOutput("bp_stable", 32'(stable), 32'd1);
        checkOutput("bp_word_count", 32'(got_words.size()), 32'd2);
        if (got_words.size() == 2) begin
            checkOutput("bp_word0", got_words[0], 32'hCCCCCCCC);
            checkOutput("bp_word1", got_words[1], 32'h33333333);
            checkOutput("bp_last0", 32'(got_last[0]), 32'd0);
            checkOutput("bp_last1", 32'(got_last[1]), 32'd1);
        end
        checkOutput("bp_done_count", 32'(done_cnt), 32'd1);

        $display("[TB] start while busy during 0..63");
        runScan(0, 63, -1, 0, 10);
        checkOutput("busy_word_count", 32'(got_words.size()), 32'd2);
        if (got_words.size() == 2) begin
            checkOutput("busy_word0", got_words[0], 32'hCCCCCCCC);
            checkOutput("busy_word1", got_words[1], 32'h33333333);
            checkOutput("busy_last1", 32'(got_last[1]), 32'd1);
        end
        checkOutput("busy_done_count", 32'(done_cnt), 32'd1);
        checkOutput("busy_final_sel", 32'(sel), 32'd64);
        checkOutput("busy_idle_after", 32'(busy), 32'd0);

        $display("[TB] reset in HOLD at word 3 of 0..511");
        mode      = 0;
        out_ready = 1'b1;
        hs        = 0;
        applyStimulus(0, 511);
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (out_valid) begin
                if (hs == 2) begin
                    out_ready = 1'b0;
                    break;
                end
                hs++;
            end
            tick();
        end
        checkOutput("rst_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_sel", 32'(sel), 32'd0);
        checkOutput("rst_async_data", out_data, 32'd0);
        checkOutput("rst_async_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_async_last", 32'(out_last), 32'd0);
        checkOutput("rst_async_busy", 32'(busy), 32'd0);
        checkOutput("rst_async_done", 32'(done), 32'd0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        runScan(0, 31, -1, 0, -1);
        checkOutput("rst_rescan_count", 32'(got_words.size()), 32'd1);
        if (got_words.size() == 1) begin
            checkOutput("rst_rescan_word", got_words[0], 32'hAAAAAAAA);
            checkOutput("rst_rescan_last", 32'(got_last[0]), 32'd1);
        end
        checkOutput("rst_rescan_done", 32'(done_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencing controller that sweeps the select input of the 512:1 binary mux tree across a programmed range and captures the tree's single-bit output. It drives `sel` directly into the tree's SEL port, waits a programmable settle time, samples Z, and packs the samples LSB-first into words. Words go out over a valid/ready stream. It is the control and capture stage wrapped around the mux tree: upstream of SEL, downstream of Z.

## Interface

- One clock; reset is asynchronous and active-low.
- `SEL_W`, default 9: select width. Range is 2^SEL_W inputs.
- `SETTLE`, default 2: idle cycles after each `sel` change before sampling. 0 is legal.
- `WORD_W`, default 32: packed output word width. Must be ≥1.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: single-cycle scan request. Honoured only in IDLE.
- `first_sel`, input, SEL_W: first select value. Latched on an accepted `start`.
- `last_sel`, input, SEL_W: last select value, inclusive. Latched on an accepted `start`.
- `sel`, output, SEL_W: registered select driven to the mux tree.
- `z_in`, input, 1: mux tree output.
- `out_data`, output, WORD_W: packed samples.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: consumer accepts the word.
- `out_last`, output, 1: qualifies the final word of a scan.
- `busy`, output, 1: high from the cycle after an accepted `start` until `done`.
- `done`, output, 1: one-cycle pulse after the last word handshakes.

## Operation

- FSM states: IDLE, SETTLE, SAMPLE, HOLD.
- **IDLE**
  - On `start`: latch the range, load `sel <= first_sel`, clear the packer, go to SETTLE, set `busy`.
- **SETTLE**
  - Counts SETTLE cycles, then goes to SAMPLE.
  - If SETTLE=0, goes straight to SAMPLE.
- **SAMPLE** (one cycle)
  - Writes `z_in` into bit `bit_idx` of the packer and advances `sel` by +1, modulo 2^SEL_W.
  - If the word is now full or this was the last sample: go to HOLD.
  - Otherwise: go to SETTLE.
- **HOLD**
  - `out_valid` is high.
  - `out_data`, `out_last` and `sel` are held stable until `out_valid && out_ready`.
  - On handshake, if the last sample was taken: pulse `done`, clear `busy`, return to IDLE.
  - On handshake otherwise: clear the packer and go to SETTLE.
- **Sample count:** ((last_sel − first_sel) mod 2^SEL_W) + 1, range 1..2^SEL_W.
  - Wrap-around is legal: `last_sel < first_sel` sweeps through 2^SEL_W−1 to 0.
  - `first_sel == last_sel` gives exactly one sample.
  - Full range (e.g. first=0, last=511) gives 512 samples.
  - The sample counter is SEL_W+1 bits wide.
- **Packing:** sample k of a word lands in bit k. Unused upper bits of a partial final word are 0.
- `start` while not in IDLE is ignored, with no side effects.
- The `start` input is not sampled in the cycle `done` pulses. The FSM is in IDLE from the next cycle.

## Timing

- **Reset values:** `sel`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, FSM=IDLE.
- **Reset mid-scan:** asserting `rst_n` low forces all reset values immediately (asynchronous), and any pending word is dropped. Deassertion is synchronised externally.
- **Start latency:**
  - `start` at cycle 0 → `sel=first_sel` and `busy=1` at cycle 1.
  - First sample at cycle 1+SETTLE.
  - `out_valid` at cycle 2+SETTLE if that sample completes a word.
- **Throughput:** one sample per SETTLE+1 cycles. No sampling happens during HOLD.
- After a handshake, the first sample of the next word is taken SETTLE+1 cycles later.
- `done` is asserted the cycle after the final handshake, coincident with `busy` falling.
- `z_in` is sampled only in SAMPLE. The mux tree is combinational, so `z_in` is valid after settling.

## Structure

- **Package `mux_scan_pkg`:**
  - state enum `scan_state_e` (IDLE, SETTLE, SAMPLE, HOLD);
  - default constants `SCAN_SEL_W=9`, `SCAN_WORD_W=32`.
- **Sub-module `mux_scan_pack`:**
  - WORD_W packer with bit index, `clear`, `push(bit)` and `full`;
  - zero-fills on clear.
- The top level holds the FSM, the settle counter and the sample counter.

## Test plan

All scenarios use SEL_W=9, SETTLE=2, WORD_W=32, with `out_ready=1` unless stated.

- **Full sweep:** `z_in = sel[0]`, first=0, last=511 → 16 words, each 0xAAAAAAAA; `out_last` only on word 16; `done` one cycle after; 512 SAMPLE states.
- **Single sample:** first=last=10, `z_in=1`, `start` at cycle 0 → `sel`=10 at cycle 1, sample at cycle 3, `out_valid` at cycle 4 with `out_data`=0x00000001 and `out_last`=1; `done` at cycle 5.
- **Wrap-around:** first=510, last=1, `z_in=1` only when `sel`=511 → `sel` sequence 510, 511, 0, 1; one word 0x00000002 with `out_last`=1.
- **Backpressure:** `out_ready` low for 20 cycles on the first word of scan 0..63 → `out_valid`, `out_data` and `sel` (=32) stable for the whole stall; after release, word 2 is correct and there are no duplicated or lost samples.
- **Reset mid-scan:** `rst_n` low in HOLD at word 3 of 0..511 → all outputs at reset values in the same cycle; a new `start` with 0..31 then yields one correct word.
- **Start while busy:** second `start` with first=100 during scan 0..63 → ignored; output identical to the undisturbed run, exactly one `done`.
